// File: rtl/interleaver_pkg.sv
// ---------------------------------------------------------------------------
// interleaver_pkg
//   Definitions shared by the interleaver buffer blocks.
//   - wr_state_t          : 3-bit state encoding of the buffer writer FSM
//   - interleaver_addr_w  : address width for a ROW x COL block, $clog2(ROW*COL)
// ---------------------------------------------------------------------------
package interleaver_pkg;

    typedef enum logic [2:0] {
        ST_INIT           = 3'd0,
        ST_WAIT_IN_FIFO   = 3'd1,
        ST_READ_FIFO      = 3'd2,
        ST_GET_FIFO_DATA  = 3'd3,
        ST_WRITE_BUFF     = 3'd4,
        ST_SET_READ_START = 3'd5
    } wr_state_t;

    // A degenerate 1-bit block still needs a 1-bit address bus.
    function automatic int interleaver_addr_w(input int row, input int col);
        return (row * col > 1) ? $clog2(row * col) : 1;
    endfunction

endpackage

// File: rtl/interleaver_addr_gen.sv
// ---------------------------------------------------------------------------
// interleaver_addr_gen
//   Column-major address generator for row-major input. Bit k of a block
//   enters at row k/COL, column k%COL and is stored at col*ROW + row. The
//   address is built incrementally (step by ROW inside a row, restart at the
//   next row index on row wrap), so no multiplier or divider is needed.
// Ports
//   clk     in   1    clock, rising edge
//   rst     in   1    asynchronous active-high reset
//   clear   in   1    restart at bit 0 of a block
//   advance in   1    current bit has been written, step to the next one
//   addr    out  AW   address of the current bit within the half
//   last    out  1    current bit is the final bit (N-1) of the block
// ---------------------------------------------------------------------------
module interleaver_addr_gen
    import interleaver_pkg::*;
#(
    parameter  int ROW_NUMBER = 10,
    parameter  int COL_NUMBER = 7,
    localparam int AW         = interleaver_addr_w(ROW_NUMBER, COL_NUMBER),
    localparam int RW         = (ROW_NUMBER > 1) ? $clog2(ROW_NUMBER) : 1,
    localparam int CW         = (COL_NUMBER > 1) ? $clog2(COL_NUMBER) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [AW-1:0] addr,
    output logic          last
);

    logic [RW-1:0] row_cnt;
    logic [CW-1:0] col_cnt;
    logic [AW-1:0] addr_reg;

    logic col_wrap;

    assign col_wrap = (col_cnt == CW'(COL_NUMBER - 1));
    assign last     = col_wrap && (row_cnt == RW'(ROW_NUMBER - 1));
    assign addr     = addr_reg;

    // Counter update. On the final bit everything wraps to zero so addr_reg
    // stays within 0..N-1 even before the writer's INIT clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt  <= '0;
            col_cnt  <= '0;
            addr_reg <= '0;
        end else if (clear) begin
            row_cnt  <= '0;
            col_cnt  <= '0;
            addr_reg <= '0;
        end else if (advance) begin
            if (last) begin
                row_cnt  <= '0;
                col_cnt  <= '0;
                addr_reg <= '0;
            end else if (col_wrap) begin
                col_cnt  <= '0;
                row_cnt  <= row_cnt + RW'(1);
                addr_reg <= AW'(row_cnt) + AW'(1);
            end else begin
                col_cnt  <= col_cnt + CW'(1);
                addr_reg <= addr_reg + AW'(ROW_NUMBER);
            end
        end
    end

endmodule

// File: rtl/interleaver_write_buffer.sv
// ---------------------------------------------------------------------------
// interleaver_write_buffer
//   Writer side of the interleaver ping-pong buffer. Pops bits from the input
//   FIFO in row-major order and writes each one to the current half at its
//   column-major address. When a half holds a full block it raises READ_START
//   and waits for READ_ACK, then toggles to the other half.
// Ports
//   CLK                in   1    clock, rising edge
//   RESET              in   1    asynchronous active-high reset
//   FIFO_DATA          in   1    FIFO read data, valid the cycle after FIFO_READ
//   FIFO_READ          out  1    FIFO pop strobe
//   FIFO_EMPTY         in   1    FIFO empty flag
//   BUFF_DATA          out  1    buffer write data
//   BUFF_ADDR          out  AW   buffer write address within the half
//   BUFF_WE            out  1    buffer write enable
//   BUFF_SEL           out  1    half being written
//   READ_START         out  1    half full, waiting for the read side
//   READ_ACK           in   1    read side accepted the half
//   PING_PONG_FLAG_OUT out  1    half handed over, valid while READ_START=1
// ---------------------------------------------------------------------------
module interleaver_write_buffer
    import interleaver_pkg::*;
#(
    parameter  int ROW_NUMBER = 10,
    parameter  int COL_NUMBER = 7,
    localparam int AW         = interleaver_addr_w(ROW_NUMBER, COL_NUMBER)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          FIFO_DATA,
    output logic          FIFO_READ,
    input  logic          FIFO_EMPTY,
    output logic          BUFF_DATA,
    output logic [AW-1:0] BUFF_ADDR,
    output logic          BUFF_WE,
    output logic          BUFF_SEL,
    output logic          READ_START,
    input  logic          READ_ACK,
    output logic          PING_PONG_FLAG_OUT
);

    wr_state_t     state;
    wr_state_t     state_next;
    logic          write_sel;
    logic          data_internal;
    logic [AW-1:0] addr;
    logic          last;
    logic          clear;
    logic          advance;

    assign clear   = (state == ST_INIT);
    assign advance = (state == ST_WRITE_BUFF);

    interleaver_addr_gen #(
        .ROW_NUMBER (ROW_NUMBER),
        .COL_NUMBER (COL_NUMBER)
    ) u_addr_gen (
        .clk     (CLK),
        .rst     (RESET),
        .clear   (clear),
        .advance (advance),
        .addr    (addr),
        .last    (last)
    );

    // State register plus the two data registers it controls: the bit popped
    // from the FIFO and the half currently being filled. The half only flips
    // once the read side has accepted the full one.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= ST_INIT;
            write_sel     <= 1'b0;
            data_internal <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_GET_FIFO_DATA) begin
                data_internal <= FIFO_DATA;
            end
            if ((state == ST_SET_READ_START) && READ_ACK) begin
                write_sel <= ~write_sel;
            end
        end
    end

    // Next-state logic and Moore output decode. Outputs depend only on the
    // registered state, so an asynchronous reset clears them immediately.
    always_comb begin
        state_next         = ST_INIT;
        FIFO_READ          = 1'b0;
        BUFF_WE            = 1'b0;
        BUFF_DATA          = 1'b0;
        BUFF_ADDR          = '0;
        READ_START         = 1'b0;
        PING_PONG_FLAG_OUT = 1'b0;
        BUFF_SEL           = write_sel;

        case (state)
            ST_INIT: begin
                state_next = ST_WAIT_IN_FIFO;
            end
            ST_WAIT_IN_FIFO: begin
                state_next = FIFO_EMPTY ? ST_WAIT_IN_FIFO : ST_READ_FIFO;
            end
            ST_READ_FIFO: begin
                FIFO_READ  = 1'b1;
                state_next = ST_GET_FIFO_DATA;
            end
            ST_GET_FIFO_DATA: begin
                state_next = ST_WRITE_BUFF;
            end
            ST_WRITE_BUFF: begin
                BUFF_WE    = 1'b1;
                BUFF_DATA  = data_internal;
                BUFF_ADDR  = addr;
                state_next = last ? ST_SET_READ_START : ST_WAIT_IN_FIFO;
            end
            ST_SET_READ_START: begin
                READ_START         = 1'b1;
                PING_PONG_FLAG_OUT = write_sel;
                state_next         = READ_ACK ? ST_INIT : ST_SET_READ_START;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_interleaver_write_buffer.sv
// ---------------------------------------------------------------------------
// tb_interleaver_write_buffer
//   Self-checking bench for interleaver_write_buffer with a 3x2 block.
//   A behavioural FIFO feeds the writer, a monitor records every buffer write
//   into a two-half memory image, and expected addresses / readout order are
//   computed from the row/column interleaving rule.
// ---------------------------------------------------------------------------
module tb_interleaver_write_buffer;

    localparam int ROW = 3;
    localparam int COL = 2;
    localparam int N   = ROW * COL;
    localparam int AW  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          fifoData;
    logic          fifoRead;
    logic          fifoEmpty;
    logic          buffData;
    logic [AW-1:0] buffAddr;
    logic          buffWe;
    logic          buffSel;
    logic          readStart;
    logic          readAck;
    logic          pingPongFlag;

    logic [8:0]    allOutputs;

    int assertCnt = 0;
    int failCnt   = 0;

    // Behavioural input FIFO
    logic fifoMem [0:255];
    int   wrPtr = 0;
    int   rdPtr = 0;
    logic fifoDataReg = 1'b0;

    // Monitor records
    logic          monEnable = 1'b0;
    int            wrCnt     = 0;
    int            fifoRdCnt = 0;
    int            violCnt   = 0;
    logic [AW-1:0] wrAddr [0:255];
    logic          wrData [0:255];
    logic          wrSel  [0:255];
    logic          tbMem  [0:1][0:7];
    logic          pending [0:1];

    interleaver_write_buffer #(
        .ROW_NUMBER (ROW),
        .COL_NUMBER (COL)
    ) dut (
        .CLK                (clk),
        .RESET              (reset),
        .FIFO_DATA          (fifoData),
        .FIFO_READ          (fifoRead),
        .FIFO_EMPTY         (fifoEmpty),
        .BUFF_DATA          (buffData),
        .BUFF_ADDR          (buffAddr),
        .BUFF_WE            (buffWe),
        .BUFF_SEL           (buffSel),
        .READ_START         (readStart),
        .READ_ACK           (readAck),
        .PING_PONG_FLAG_OUT (pingPongFlag)
    );

    always #5 clk = ~clk;

    assign fifoEmpty  = (rdPtr == wrPtr);
    assign fifoData   = fifoDataReg;
    assign allOutputs = {fifoRead, buffData, buffAddr, buffWe, buffSel, readStart, pingPongFlag};

    // FIFO read port: data appears the cycle after the pop strobe.
    always @(posedge clk) begin
        if (fifoRead && (rdPtr != wrPtr)) begin
            fifoDataReg <= fifoMem[rdPtr];
            rdPtr       <= rdPtr + 1;
        end
    end

    // Monitor on the falling edge: log writes, count pops and flag any write
    // into a half that has been offered to the read side but not yet acked.
    always @(negedge clk) begin
        if (reset) begin
            pending[0] = 1'b0;
            pending[1] = 1'b0;
        end else if (monEnable) begin
            if (fifoRead) fifoRdCnt++;
            if (buffWe) begin
                wrAddr[wrCnt] = buffAddr;
                wrData[wrCnt] = buffData;
                wrSel[wrCnt]  = buffSel;
                tbMem[buffSel][buffAddr] = buffData;
                if (pending[buffSel]) violCnt++;
                wrCnt++;
            end
            if (readStart) begin
                pending[pingPongFlag] = 1'b1;
                if (readAck) pending[pingPongFlag] = 1'b0;
            end
        end
    end

    // Global safety net so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, failures so far %0d", failCnt);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCnt++;
        assert (observed === expected) else begin
            failCnt++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyBit(input logic b);
        fifoMem[wrPtr] = b;
        wrPtr          = wrPtr + 1;
    endtask

    task automatic applyStimulus(input int count);
        for (int i = 0; i < count; i++) begin
            applyBit(1'($urandom_range(0, 1)));
        end
    endtask

    // Interleaving rule: bit k sits at row k/COL, column k%COL.
    function automatic int expAddr(input int k);
        return (k % COL) * ROW + (k / COL);
    endfunction

    task automatic waitWrites(input int target, input string tag);
        int n = 0;
        while ((wrCnt < target) && (n < 400)) begin
            tick();
            n++;
        end
        checkOutput(tag, wrCnt, target);
    endtask

    task automatic waitReadStart(input string tag);
        int n = 0;
        while ((readStart !== 1'b1) && (n < 100)) begin
            tick();
            n++;
        end
        checkOutput(tag, {31'd0, readStart}, 1);
    endtask

    task automatic checkBlock(input int w0, input int f0, input logic sel, input string tag);
        for (int k = 0; k < N; k++) begin
            checkOutput($sformatf("%s addr[%0d]", tag, k), {29'd0, wrAddr[w0 + k]}, expAddr(k));
            checkOutput($sformatf("%s data[%0d]", tag, k), {31'd0, wrData[w0 + k]}, {31'd0, fifoMem[f0 + k]});
            checkOutput($sformatf("%s sel[%0d]", tag, k), {31'd0, wrSel[w0 + k]}, {31'd0, sel});
        end
    endtask

    // Sequential readout of a half must give the column-major order.
    task automatic checkReadout(input logic half, input int f0, input string tag);
        for (int a = 0; a < N; a++) begin
            checkOutput($sformatf("%s readout[%0d]", tag, a), {31'd0, tbMem[half][a]},
                        {31'd0, fifoMem[f0 + (a % ROW) * COL + (a / ROW)]});
        end
    endtask

    task automatic pulseAck(input string tag);
        readAck = 1'b1;
        tick();
        readAck = 1'b0;
        checkOutput(tag, {31'd0, readStart}, 0);
    endtask

    initial begin
        int   w0;
        int   f0;
        int   holdW;
        int   holdR;
        logic expSel;
        logic pattern [0:5];
        int   patAddr [0:5];

        pattern = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        patAddr = '{0, 3, 1, 4, 2, 5};
        reset   = 1'b0;
        readAck = 1'b0;

        // Reset asserted mid-cycle clears every output immediately
        tick();
        tick();
        #2 reset = 1'b1;
        #1 checkOutput("async_reset_outputs", {23'd0, allOutputs}, 0);
        tick();
        tick();
        reset     = 1'b0;
        monEnable = 1'b1;
        tick();
        checkOutput("post_reset_buff_sel", {31'd0, buffSel}, 0);
        checkOutput("post_reset_outputs", {23'd0, allOutputs}, 0);

        // Directed block 1,0,1,1,0,0 into half 0
        for (int i = 0; i < N; i++) applyBit(pattern[i]);
        waitWrites(N, "blk1_write_count");
        for (int k = 0; k < N; k++) begin
            checkOutput($sformatf("blk1 addr[%0d]", k), {29'd0, wrAddr[k]}, patAddr[k]);
            checkOutput($sformatf("blk1 data[%0d]", k), {31'd0, wrData[k]}, {31'd0, pattern[k]});
            checkOutput($sformatf("blk1 sel[%0d]", k), {31'd0, wrSel[k]}, 0);
        end
        waitReadStart("blk1_read_start");
        checkOutput("blk1_fifo_reads", fifoRdCnt, N);
        checkOutput("blk1_ping_pong", {31'd0, pingPongFlag}, 0);
        checkReadout(1'b0, 0, "blk1");

        // Read side stays busy for 20 cycles
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput($sformatf("hold_read_start[%0d]", i), {31'd0, readStart}, 1);
        end
        checkOutput("hold_fifo_reads", fifoRdCnt, N);
        pulseAck("blk1_ack_drop");
        checkOutput("blk2_buff_sel", {31'd0, buffSel}, 1);

        // Block into half 1 with a FIFO gap after the third bit
        w0 = wrCnt;
        f0 = rdPtr;
        applyStimulus(3);
        waitWrites(w0 + 3, "gap_first_writes");
        holdW = wrCnt;
        holdR = fifoRdCnt;
        repeat (15) tick();
        checkOutput("gap_no_write", wrCnt, holdW);
        checkOutput("gap_no_fifo_read", fifoRdCnt, holdR);
        applyStimulus(3);
        waitWrites(w0 + N, "gap_block_writes");
        checkOutput("gap_resume_addr", {29'd0, wrAddr[w0 + 3]}, 4);
        checkBlock(w0, f0, 1'b1, "blk2");
        waitReadStart("blk2_read_start");
        checkOutput("blk2_ping_pong", {31'd0, pingPongFlag}, 1);
        checkReadout(1'b1, f0, "blk2");
        pulseAck("blk2_ack_drop");

        // Three back-to-back random blocks
        w0     = wrCnt;
        f0     = rdPtr;
        expSel = 1'b0;
        applyStimulus(3 * N);
        for (int b = 0; b < 3; b++) begin
            waitWrites(w0 + (b + 1) * N, $sformatf("b2b%0d_writes", b));
            waitReadStart($sformatf("b2b%0d_read_start", b));
            checkOutput($sformatf("b2b%0d_ping_pong", b), {31'd0, pingPongFlag}, {31'd0, expSel});
            checkBlock(w0 + b * N, f0 + b * N, expSel, $sformatf("b2b%0d", b));
            checkReadout(expSel, f0 + b * N, $sformatf("b2b%0d", b));
            pulseAck($sformatf("b2b%0d_ack_drop", b));
            expSel = ~expSel;
        end
        checkOutput("overwrite_violations", violCnt, 0);

        // Reset in the middle of a block in half 1
        checkOutput("pre_reset_buff_sel", {31'd0, buffSel}, 1);
        w0 = wrCnt;
        applyStimulus(N);
        waitWrites(w0 + 4, "midblk_writes");
        tick();
        #2 reset = 1'b1;
        #1 checkOutput("midblk_reset_outputs", {23'd0, allOutputs}, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        checkOutput("midblk_post_reset_sel", {31'd0, buffSel}, 0);
        w0 = wrCnt;
        f0 = rdPtr;
        applyStimulus(N);
        waitWrites(w0 + N, "after_reset_writes");
        checkBlock(w0, f0, 1'b0, "after_reset");
        waitReadStart("after_reset_read_start");
        checkOutput("after_reset_ping_pong", {31'd0, pingPongFlag}, 0);
        pulseAck("after_reset_ack_drop");
        checkOutput("final_violations", violCnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
